rf_write_arbiter: RTL and testbench

Shares the register file's single synchronous write port between the in-order WB stage and the multi-cycle M-extension unit (MDU). Keeps a per-register pending scoreboard so decode stalls on operands whose MDU result has not yet been written. Sits between WB/MDU and `reg_file`, and drives `reg_file`'s `rd_addr`, `rd_data` and `wen` directly.

---
 rtl/rf_arb_pkg.sv | 18 +
 rtl/rf_arb_fifo.sv | 64 ++++++
 rtl/rf_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Contents: XLEN/REG_ADDR_W, the rf_wr_t write record, default FIFO depth and starve limit.
// No logic; imported by rf_arb_fifo and rf_write_arbiter.
package rf_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  localparam int RF_ARB_FIFO_DEPTH   = 2;
  localparam int RF_ARB_STARVE_LIMIT = 8;

endpackage

// File: rtl/rf_arb_fifo.sv
// Purpose: small synchronous FIFO of rf_wr_t buffering MDU results for the write port.
// Latency: push registered, head visible the cycle after the first push; pop is immediate.
// Backpressure: full/empty are registered-state flags; push while full or pop while empty is ignored.
// Ports: clk, rst_n (async active-low), push_vld/push_dat, pop, head_dat, full, empty.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = RF_ARB_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_vld,
  input  rf_wr_t push_dat,
  input  logic   pop,
  output rf_wr_t head_dat,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rf_wr_t      mem_q [DEPTH];
  rf_wr_t      mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Purpose: shares the regfile's single write port between WB (priority) and buffered MDU results,
//          and keeps a per-register pending scoreboard for decode operand stalls.
// Latency: MDU result to regfile write >= 1 cycle (exactly 1 with WB idle and buffer empty).
// Backpressure: WB is never stalled; mdu_res_ready = !fifo_full; mdu_issue_ready = !pending[rd].
// Ports: clk, rst_n; wb_wen/wb_rd/wb_data; mdu_issue_valid/rd/ready; mdu_res_valid/rd/data/ready;
//        rs1_addr/rs2_addr -> rs1_busy/rs2_busy; rf_wen/rf_rd/rf_data to reg_file; waw_err; hold_pipe.
// Optional: RF_ARB_STARVE_GUARD_EN enables the starvation counter driving hold_pipe.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = RF_ARB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = RF_ARB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  mdu_issue_valid,
  input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
  output logic                  mdu_issue_ready,
  input  logic                  mdu_res_valid,
  input  logic [REG_ADDR_W-1:0] mdu_res_rd,
  input  logic [XLEN-1:0]       mdu_res_data,
  output logic                  mdu_res_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_data,
  output logic                  waw_err,
  output logic                  hold_pipe
);

  logic   [31:0] pend_q, pend_d;
  logic          waw_q, waw_d;
  logic          wb_eff;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          issue_set;
  rf_wr_t        push_dat;
  rf_wr_t        head_dat;

  assign wb_eff          = wb_wen && (wb_rd != '0);
  assign mdu_res_ready   = !fifo_full;
  // rd=0 results are accepted but never buffered, so x0 is never written.
  assign fifo_push       = mdu_res_valid && mdu_res_ready && (mdu_res_rd != '0);
  assign fifo_pop        = !wb_eff && !fifo_empty;
  assign mdu_issue_ready = (mdu_issue_rd == '0) || !pend_q[mdu_issue_rd];
  assign issue_set       = mdu_issue_valid && mdu_issue_ready && (mdu_issue_rd != '0);
  assign push_dat        = '{rd: mdu_res_rd, data: mdu_res_data};
  assign rs1_busy        = pend_q[rs1_addr];
  assign rs2_busy        = pend_q[rs2_addr];
  assign waw_err         = waw_q;

  rf_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write-port mux: WB first, then FIFO head; address/data idle at zero.
  always_comb begin
    rf_wen  = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    if (wb_eff) begin
      rf_wen  = 1'b1;
      rf_rd   = wb_rd;
      rf_data = wb_data;
    end else if (!fifo_empty) begin
      rf_wen  = 1'b1;
      rf_rd   = head_dat.rd;
      rf_data = head_dat.data;
    end
  end

  // Clear is applied before set so a same-cycle reissue keeps the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop) begin
      pend_d[head_dat.rd] = 1'b0;
    end
    if (issue_set) begin
      pend_d[mdu_issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
    waw_d     = waw_q || (wb_eff && pend_q[wb_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      waw_q  <= waw_d;
    end
  end

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             hold_q, hold_d;

  // Counts cycles the buffered head is locked out by WB; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_pop) begin
      starve_cnt_d = '0;
    end else if (!fifo_empty && wb_eff && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    hold_d = (starve_cnt_d == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      hold_q       <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      hold_q       <= hold_d;
    end
  end

  assign hold_pipe = hold_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign hold_pipe           = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_issue_valid;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_issue_ready;
  logic        mdu_res_valid;
  logic [4:0]  mdu_res_rd;
  logic [31:0] mdu_res_data;
  logic        mdu_res_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        waw_err;
  logic        hold_pipe;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_wen          (wb_wen),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .mdu_issue_valid (mdu_issue_valid),
    .mdu_issue_rd    (mdu_issue_rd),
    .mdu_issue_ready (mdu_issue_ready),
    .mdu_res_valid   (mdu_res_valid),
    .mdu_res_rd      (mdu_res_rd),
    .mdu_res_data    (mdu_res_data),
    .mdu_res_ready   (mdu_res_ready),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .rf_wen          (rf_wen),
    .rf_rd           (rf_rd),
    .rf_data         (rf_data),
    .waw_err         (waw_err),
    .hold_pipe       (hold_pipe)
  );

  // Reference model: ordered list of buffered results, set of pending registers.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   pend[32];
  bit   m_waw;
  bit   m_hold;
  int   m_starve;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_waw    = 1'b0;
    m_hold   = 1'b0;
    m_starve = 0;
  endtask

  task automatic drive_idle();
    wb_wen = 0; wb_rd = 0; wb_data = 0;
    mdu_issue_valid = 0; mdu_issue_rd = 0;
    mdu_res_valid = 0; mdu_res_rd = 0; mdu_res_data = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  // One cycle: drive on the falling edge, check settled outputs, advance the model.
  task automatic step(input bit ww, input logic [4:0] wrd, input logic [31:0] wd,
                      input bit iv, input logic [4:0] ird,
                      input bit rv, input logic [4:0] rrd, input logic [31:0] rd_data,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit   wb_eff, pop, push, exp_rdy, exp_irdy, exp_wen;
    ent_t head;
    @(negedge clk);
    if (m_hold) ww = 1'b0;  // pipeline honours the bubble request
    wb_wen = ww; wb_rd = wrd; wb_data = wd;
    mdu_issue_valid = iv; mdu_issue_rd = ird;
    mdu_res_valid = rv; mdu_res_rd = rrd; mdu_res_data = rd_data;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    wb_eff   = ww && (wrd != 0);
    exp_rdy  = (q.size() < DEPTH);
    exp_irdy = (ird == 0) || !pend[ird];
    exp_wen  = wb_eff || (q.size() > 0);
    chk("rf_wen", {31'b0, rf_wen}, {31'b0, exp_wen});
    if (wb_eff) begin
      chk("rf_rd_wb", {27'b0, rf_rd}, {27'b0, wrd});
      chk("rf_data_wb", rf_data, wd);
    end else if (q.size() > 0) begin
      chk("rf_rd_mdu", {27'b0, rf_rd}, {27'b0, q[0].rd});
      chk("rf_data_mdu", rf_data, q[0].data);
    end
    chk("res_ready", {31'b0, mdu_res_ready}, {31'b0, exp_rdy});
    chk("issue_ready", {31'b0, mdu_issue_ready}, {31'b0, exp_irdy});
    chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, pend[r1]});
    chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, pend[r2]});
    chk("waw_err", {31'b0, waw_err}, {31'b0, m_waw});
    chk("hold_pipe", {31'b0, hold_pipe}, {31'b0, m_hold});
    // Next-state of the model.
    pop  = !wb_eff && (q.size() > 0);
    push = rv && exp_rdy && (rrd != 0);
    if (wb_eff && pend[wrd]) m_waw = 1'b1;
`ifdef RF_ARB_STARVE_GUARD_EN
    if (pop) m_starve = 0;
    else if (q.size() > 0 && wb_eff && m_starve < LIMIT) m_starve++;
    m_hold = (m_starve >= LIMIT);
`endif
    if (pop) begin
      head = q.pop_front();
      pend[head.rd] = 1'b0;
    end
    if (iv && exp_irdy && ird != 0) pend[ird] = 1'b1;
    if (push) q.push_back('{rd: rrd, data: rd_data});
  endtask

  task automatic idle_step(input logic [4:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    model_clear();
    chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("rst_rf_rd", {27'b0, rf_rd}, 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_res_ready", {31'b0, mdu_res_ready}, 32'd1);
    chk("rst_issue_ready", {31'b0, mdu_issue_ready}, 32'd1);
    chk("rst_waw", {31'b0, waw_err}, 32'd0);
    chk("rst_hold", {31'b0, hold_pipe}, 32'd0);
    for (int r = 0; r < 32; r += 2) begin
      rs1_addr = 5'(r); rs2_addr = 5'(r + 1);
      #1;
      chk("rst_busy1", {31'b0, rs1_busy}, 32'd0);
      chk("rst_busy2", {31'b0, rs2_busy}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bias;
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    apply_reset();
    idle_step(0);  // write-free cycle after reset

    // x5 issued, result 0x2A with WB idle: written one cycle after accept.
    step(0, 0, 0, 1, 5, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 1, 5, 32'h0000_002A, 5, 0);
    idle_step(5);
    idle_step(5);

    // WB hammers x3 while x6/x7 results arrive; buffer fills, then drains in order.
    step(0, 0, 0, 1, 6, 0, 0, 0, 6, 7);
    step(0, 0, 0, 1, 7, 0, 0, 0, 6, 7);
    for (int i = 0; i < 12; i++)
      step(1, 3, 32'h3300 + i, 0, 0, (i < 4), (i == 0) ? 5'd6 : 5'd7,
           32'h600 + i, 6, 7);
    for (int i = 0; i < 4; i++) idle_step(6);

    // Double issue of x8, then drain; unissued x8 result popped alongside a reissue.
    step(0, 0, 0, 1, 8, 0, 0, 0, 8, 0);
    step(0, 0, 0, 1, 8, 1, 8, 32'h88, 8, 0);
    step(0, 0, 0, 1, 8, 0, 0, 0, 8, 0);
    idle_step(8);
    apply_reset();
    step(0, 0, 0, 0, 0, 1, 8, 32'h8, 8, 0);
    step(0, 0, 0, 1, 8, 0, 0, 0, 8, 0);
    idle_step(8);

    // WAW on pending x9, and x0 issue/result.
    step(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    step(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 1, 0, 1, 0, 32'hDEAD, 0, 9);
    idle_step(0);

    // Randomized traffic with occasional mid-run resets.
    bias = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) bias = (n / 64 % 3 == 0) ? 20 : ((n / 64 % 3 == 1) ? 60 : 95);
      if (n % 997 == 500) apply_reset();
      step($urandom_range(99) < bias, 5'($urandom_range(0, 9)), $urandom,
           $urandom_range(1), 5'($urandom_range(0, 9)),
           $urandom_range(2) == 0, 5'($urandom_range(0, 9)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
